priority_encoder_seq: RTL and testbench
=======================================

# priority_encoder_seq

Parametrised, sequential successor to the combinational 8-bit priority encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake and emits the index of every set bit, one per output beat, in priority order. A last flag marks the final beat of each vector, and an empty flag reports a vector with no bits set. It sits between request-collection logic and a downstream consumer that services one index at a time, such as an interrupt or arbitration dispatcher.

## Interface
- WIDTH, 8: request vector width; must be at least 2.
- LSB_FIRST, 0: 0 serves the highest set index first (MSB priority); 1 serves the lowest set index first.
- CODE_W, $clog2(WIDTH): derived localparam, the width of code.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  request vector, sampled on input handshake.
- in_valid  input  1  in is valid.
- in_ready  output  1  block can accept a vector this cycle.
- code  output  CODE_W  index of the set bit currently presented.
- valid  output  1  code/last/empty are valid.
- last  output  1  current beat is the final one of its vector.
- empty  output  1  current beat reports a zero vector; code=0.
- out_ready  input  1  consumer accepts the current beat.

## Operation
- State: pending[WIDTH] holds the bits not yet presented. Registered outputs are code, valid, last and empty.
- Two modes, derived from valid:
  - IDLE: valid=0.
  - BUSY: valid=1.
- in_ready = !valid || (out_ready && last). It is combinational from registered state plus out_ready.
- Load, when in_valid && in_ready:
  - p = priority index of in (highest set bit if LSB_FIRST=0, lowest if LSB_FIRST=1).
  - code <= p; pending <= in with bit p cleared; last <= (pending_next == 0); empty <= 0; valid <= 1.
  - Zero vector: code <= 0, empty <= 1, last <= 1, valid <= 1, pending <= 0. Exactly one beat is produced.
- Advance, when valid && out_ready && !last:
  - code <= priority index of pending; that bit is cleared from pending.
  - last <= 1 when the remaining pending is 0.
- Finish, when valid && out_ready && last: if no load occurs the same cycle, valid <= 0 and last <= 0.
- Simultaneous finish and load: the load wins. The new vector's first beat is valid on the next cycle with no bubble.
- Backpressure: while valid && !out_ready, code, last, empty and pending hold stable.
- A vector with k set bits (k≥1) produces exactly k beats with strictly monotonic codes (descending if LSB_FIRST=0, ascending if LSB_FIRST=1).
- in is ignored when in_ready=0. There is no buffering beyond the single in-flight vector.

## Timing
- Reset values: valid=0, code=0, last=0, empty=0, pending=0. After reset, in_ready=1.
- Reset mid-burst discards pending and the current beat. valid=0 on the cycle after rst is sampled high.
- Latency: a vector accepted at edge N presents its first beat after edge N (visible in cycle N+1).
- Throughput: one beat per cycle under continuous out_ready. A k-bit vector occupies k cycles; a zero vector occupies 1 cycle.
- Priority-select logic is a single-cycle combinational scan of WIDTH bits. No multi-cycle paths.

## Test plan
- Zero vector: reset, then in=8'h00 with in_valid=1 for one cycle → next cycle valid=1, empty=1, last=1, code=0. After out_ready, valid=0.
- MSB-first burst (WIDTH=8, LSB_FIRST=0): in=8'b10101010, out_ready=1 → codes 7,5,3,1 on consecutive cycles, last=1 only with code 1, in_ready=0 during codes 7,5,3.
- Backpressure: same vector, out_ready=0 for 3 cycles while code=5 → code stays 5, last=0, no beat lost. Sequence resumes 3,1 after out_ready=1.
- Back-to-back: present 8'h01 with in_valid=1 during the last beat of 8'h80 with out_ready=1 → code 7 (last) then code 0 (last) on the next cycle, no valid=0 gap.
- LSB-first, wide (WIDTH=16, LSB_FIRST=1): in=16'h8001 → codes 0 then 15, last on 15. in=16'hFFFF → codes 0..15 ascending, 16 beats.
- Reset mid-burst: assert rst during code 5 of 8'b10101010 → next cycle valid=0, in_ready=1, code=0. A new vector 8'h04 then yields a single beat with code 2, last=1.

Source files
------------

// File: rtl/priority_encoder_seq.sv
// priority_encoder_seq: accepts a request vector over valid/ready and
// emits the index of each set bit, one per output beat, in priority order.
// A zero vector produces a single beat flagged empty.
module priority_encoder_seq #(
  parameter  int WIDTH     = 8,
  parameter  bit LSB_FIRST = 1'b0,
  localparam int CODE_W    = $clog2(WIDTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WIDTH-1:0]  i_in,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [CODE_W-1:0] o_code,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_empty,
  input  logic              i_out_ready
);

  logic [WIDTH-1:0]  r_pending;
  logic [CODE_W-1:0] r_code;
  logic              r_valid;
  logic              r_last;
  logic              r_empty;

  logic [CODE_W-1:0] w_in_idx;
  logic [WIDTH-1:0]  w_in_rem;
  logic [CODE_W-1:0] w_pend_idx;
  logic [WIDTH-1:0]  w_pend_rem;
  logic              w_load;
  logic              w_adv;
  logic              w_fin;

  // Single-pass scan; the last hit in loop order is the winner, so the loop
  // direction alone selects MSB or LSB priority.
  function automatic logic [CODE_W-1:0] f_pick(input logic [WIDTH-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) idx = CODE_W'(i);
      end
    end
    return idx;
  endfunction

  // Pick the next index from the incoming vector and from the pending bits,
  // and compute what remains once that bit is served.
  always_comb begin
    w_in_idx   = f_pick(i_in);
    w_in_rem   = i_in & ~(WIDTH'(1) << w_in_idx);
    w_pend_idx = f_pick(r_pending);
    w_pend_rem = r_pending & ~(WIDTH'(1) << w_pend_idx);
  end

  // A new vector can enter when idle or when the final beat leaves this cycle.
  assign o_in_ready = !r_valid || (i_out_ready && r_last);
  assign w_load     = i_in_valid && o_in_ready;
  assign w_adv      = r_valid && i_out_ready && !r_last;
  assign w_fin      = r_valid && i_out_ready && r_last;

  // Beat state: load beats finish, so back-to-back vectors leave no bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_empty   <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      if (i_in == '0) begin
        r_code    <= '0;
        r_pending <= '0;
        r_last    <= 1'b1;
        r_empty   <= 1'b1;
      end else begin
        r_code    <= w_in_idx;
        r_pending <= w_in_rem;
        r_last    <= (w_in_rem == '0);
        r_empty   <= 1'b0;
      end
    end else if (w_adv) begin
      r_code    <= w_pend_idx;
      r_pending <= w_pend_rem;
      r_last    <= (w_pend_rem == '0);
    end else if (w_fin) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_code  = r_code;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_empty = r_empty;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Bench for priority_encoder_seq: an 8-bit MSB-first instance and a 16-bit
// LSB-first instance, a list-of-indices reference model checked every cycle,
// plus literal expectations from the directed scenarios.
module tb_priority_encoder_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in8;
  logic [15:0] in16;
  logic [1:0]  inv, ordy, ir, vld, lst, emp;
  logic [2:0]  code8;
  logic [3:0]  code16;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  always #5 clk = ~clk;

  priority_encoder_seq #(.WIDTH(8), .LSB_FIRST(1'b0)) u8 (
    .i_clk(clk), .i_rst(rst), .i_in(in8), .i_in_valid(inv[0]),
    .o_in_ready(ir[0]), .o_code(code8), .o_valid(vld[0]), .o_last(lst[0]),
    .o_empty(emp[0]), .i_out_ready(ordy[0]));

  priority_encoder_seq #(.WIDTH(16), .LSB_FIRST(1'b1)) u16 (
    .i_clk(clk), .i_rst(rst), .i_in(in16), .i_in_valid(inv[1]),
    .o_in_ready(ir[1]), .o_code(code16), .o_valid(vld[1]), .o_last(lst[1]),
    .o_empty(emp[1]), .i_out_ready(ordy[1]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: per instance, the ordered list of indices still to be
  // presented (head is the current beat).
  bit ev[2];
  bit eempty[2];
  int eq[2][16];
  int ehead[2];
  int elen[2];

  function automatic int code_of(input int k);
    return (k == 0) ? int'(code8) : int'(code16);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int w;
      bit rdy;
      logic [15:0] vec;
      w   = (k == 0) ? 8 : 16;
      vec = (k == 0) ? {8'h00, in8} : in16;
      if (rst) begin
        ev[k] = 1'b0;
        ehead[k] = 0;
        elen[k] = 0;
      end else begin
        rdy = !ev[k] || (ordy[k] && (elen[k] - ehead[k] == 1));
        if (ev[k] && ordy[k]) begin
          ehead[k]++;
          if (ehead[k] == elen[k]) ev[k] = 1'b0;
        end
        if (inv[k] && rdy) begin
          ehead[k] = 0;
          elen[k]  = 0;
          eempty[k] = (vec == 16'h0);
          if (vec == 16'h0) begin
            eq[k][0] = 0;
            elen[k] = 1;
          end else begin
            for (int j = 0; j < w; j++) begin
              int idx;
              idx = (k == 1) ? j : (w - 1 - j);
              if (vec[idx]) begin
                eq[k][elen[k]] = idx;
                elen[k]++;
              end
            end
          end
          ev[k] = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        int rem;
        rem = elen[k] - ehead[k];
        chk($sformatf("m%0d.in_ready", k), int'(ir[k]),
            int'(!ev[k] || (ordy[k] && rem == 1)));
        chk($sformatf("m%0d.valid", k), int'(vld[k]), int'(ev[k]));
        if (ev[k]) begin
          chk($sformatf("m%0d.code", k), code_of(k), eq[k][ehead[k]]);
          chk($sformatf("m%0d.last", k), int'(lst[k]), int'(rem == 1));
          chk($sformatf("m%0d.empty", k), int'(emp[k]), int'(eempty[k]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string name, input int k, input int code, input int last);
    chk({name, ".valid"}, int'(vld[k]), 1);
    chk({name, ".code"}, code_of(k), code);
    chk({name, ".last"}, int'(lst[k]), last);
  endtask

  // Offer a vector on instance k and wait (bounded) until it is accepted.
  task automatic offer(input int k, input logic [15:0] v);
    int n;
    n = 0;
    if (k == 0) in8 = v[7:0]; else in16 = v;
    inv[k] = 1'b1;
    while (!ir[k] && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("offer.timeout", n, 0);
    tick();
    inv[k] = 1'b0;
  endtask

  logic [15:0] tbl [6] = '{16'h0000, 16'h00FF, 16'h0081, 16'h0010, 16'h5A5A, 16'h0003};

  initial begin
    rst = 1'b1; in8 = '0; in16 = '0; inv = '0; ordy = '1;
    tick(); tick();
    rst = 1'b0;
    run = 1'b1;
    // reset state
    chk("rst.valid", int'(vld[0]), 0);
    chk("rst.code", int'(code8), 0);
    chk("rst.last", int'(lst[0]), 0);
    chk("rst.empty", int'(emp[0]), 0);
    chk("rst.in_ready", int'(ir[0]), 1);
    chk("rst16.in_ready", int'(ir[1]), 1);

    // zero vector
    ordy[0] = 1'b0; in8 = 8'h00; inv[0] = 1'b1;
    tick(); inv[0] = 1'b0;
    beat("zero", 0, 0, 1);
    chk("zero.empty", int'(emp[0]), 1);
    ordy[0] = 1'b1;
    tick();
    chk("zero.done", int'(vld[0]), 0);

    // MSB-first burst
    in8 = 8'hAA; inv[0] = 1'b1;
    tick(); inv[0] = 1'b0;
    beat("burst7", 0, 7, 0); chk("burst7.in_ready", int'(ir[0]), 0);
    tick(); beat("burst5", 0, 5, 0); chk("burst5.in_ready", int'(ir[0]), 0);
    tick(); beat("burst3", 0, 3, 0); chk("burst3.in_ready", int'(ir[0]), 0);
    tick(); beat("burst1", 0, 1, 1); chk("burst1.in_ready", int'(ir[0]), 1);
    tick(); chk("burst.done", int'(vld[0]), 0);

    // backpressure on code 5
    in8 = 8'hAA; inv[0] = 1'b1;
    tick(); inv[0] = 1'b0;
    tick(); beat("bp5", 0, 5, 0);
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); beat($sformatf("bp_hold%0d", i), 0, 5, 0);
    end
    ordy[0] = 1'b1;
    tick(); beat("bp3", 0, 3, 0);
    tick(); beat("bp1", 0, 1, 1);
    tick(); chk("bp.done", int'(vld[0]), 0);

    // back-to-back: load during final beat
    in8 = 8'h80; inv[0] = 1'b1;
    tick();
    beat("b2b7", 0, 7, 1);
    in8 = 8'h01;
    tick(); inv[0] = 1'b0;
    beat("b2b0", 0, 0, 1);
    tick(); chk("b2b.done", int'(vld[0]), 0);

    // LSB-first, 16 bits
    in16 = 16'h8001; inv[1] = 1'b1;
    tick(); inv[1] = 1'b0;
    beat("w0", 1, 0, 0);
    tick(); beat("w15", 1, 15, 1);
    tick(); chk("w.done", int'(vld[1]), 0);
    in16 = 16'hFFFF; inv[1] = 1'b1;
    tick(); inv[1] = 1'b0;
    for (int j = 0; j < 16; j++) begin
      beat($sformatf("ffff%0d", j), 1, j, int'(j == 15));
      tick();
    end
    chk("ffff.done", int'(vld[1]), 0);

    // reset mid-burst
    in8 = 8'hAA; inv[0] = 1'b1;
    tick(); inv[0] = 1'b0;
    tick(); beat("mid5", 0, 5, 0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mid.valid", int'(vld[0]), 0);
    chk("mid.in_ready", int'(ir[0]), 1);
    chk("mid.code", int'(code8), 0);
    in8 = 8'h04; inv[0] = 1'b1;
    tick(); inv[0] = 1'b0;
    beat("mid2", 0, 2, 1);
    tick(); chk("mid.done", int'(vld[0]), 0);

    // table of vectors on both instances under an irregular out_ready
    // pattern; the model checks every cycle
    fork
      for (int i = 0; i < 6; i++) offer(0, tbl[i]);
      for (int i = 0; i < 6; i++) offer(1, tbl[5 - i] ^ 16'h8000);
      for (int c = 0; c < 60; c++) begin
        ordy = {c[0] | c[2], (c % 3) != 0};
        tick();
      end
    join
    ordy = '1;
    for (int i = 0; i < 20; i++) tick();
    chk("drain.valid8", int'(vld[0]), 0);
    chk("drain.valid16", int'(vld[1]), 0);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
